// File: rtl/char_rain_engine.sv
// rtl/char_rain_engine.sv - falling-character game engine: spawn, per-frame move sweep, key hits, misses.
// Optional CHAR_RAIN_WRONG_KEY_PENALTY_EN: an unmatched key counts as a miss.
module char_rain_engine #(
  parameter int SLOTS       = 8,
  parameter int Y_W         = 10,
  parameter int X_W         = 10,
  parameter int SPEED_W     = 4,
  parameter int LOWER_BOUND = 480,
  parameter int MAX_MISS    = 8,
  localparam int IDX_W      = $clog2(SLOTS),
  localparam int CNT_W      = $clog2(SLOTS) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_tick,
  input  logic               spawn_valid,
  output logic               spawn_ready,
  input  logic [7:0]         spawn_char,
  input  logic [X_W-1:0]     spawn_x,
  input  logic [SPEED_W-1:0] spawn_speed,
  input  logic               key_valid,
  input  logic [7:0]         key_char,
  input  logic [IDX_W-1:0]   rd_idx,
  output logic               rd_active,
  output logic [7:0]         rd_char,
  output logic [X_W-1:0]     rd_x,
  output logic [Y_W-1:0]     rd_y,
  output logic               hit_pulse,
  output logic               miss_pulse,
  output logic [15:0]        score,
  output logic [7:0]         misses,
  output logic [CNT_W-1:0]   active_count,
  output logic               gameover
);

  typedef enum logic {S_IDLE, S_SWEEP} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   sweep_idx, sweep_idx_d;
  logic               pend_q, pend_d;

  logic [SLOTS-1:0]   act_q;
  logic [7:0]         chr_q [SLOTS];
  logic [X_W-1:0]     x_q   [SLOTS];
  logic [Y_W-1:0]     y_q   [SLOTS];
  logic [SPEED_W-1:0] spd_q [SLOTS];

  logic [IDX_W-1:0]   spawn_slot, key_slot;
  logic               spawn_fire, key_found, key_hit, key_miss;
  logic [Y_W-1:0]     best_y;
  logic               sweep_en, sweep_out, sweep_move;
  logic [Y_W:0]       sweep_sum;
  logic [1:0]         miss_inc;
  logic [8:0]         misses_sum;
  logic [7:0]         misses_d;
  logic [CNT_W-1:0]   count_d;

  assign spawn_ready = !gameover && (act_q != {SLOTS{1'b1}});
  assign spawn_fire  = spawn_valid && spawn_ready;

  always_comb begin
    spawn_slot = '0;
    for (int i = SLOTS - 1; i >= 0; i--)
      if (!act_q[i]) spawn_slot = IDX_W'(i);
  end

  // Deepest matching character wins; strict compare keeps the lowest index on ties.
  always_comb begin
    key_found = 1'b0;
    key_slot  = '0;
    best_y    = '0;
    for (int i = 0; i < SLOTS; i++) begin
      if (act_q[i] && chr_q[i] == key_char && (!key_found || y_q[i] > best_y)) begin
        key_found = 1'b1;
        key_slot  = IDX_W'(i);
        best_y    = y_q[i];
      end
    end
  end

  assign key_hit = key_valid && key_found && !gameover;
`ifdef CHAR_RAIN_WRONG_KEY_PENALTY_EN
  assign key_miss = key_valid && !key_found && !gameover;
`else
  assign key_miss = 1'b0;
`endif

  // A key hit on the slot being swept frees it without counting a miss.
  assign sweep_en   = (state_q == S_SWEEP) && !gameover && act_q[sweep_idx];
  assign sweep_sum  = {1'b0, y_q[sweep_idx]} + (Y_W+1)'(spd_q[sweep_idx]);
  assign sweep_out  = sweep_en && (sweep_sum >= (Y_W+1)'(LOWER_BOUND))
                      && !(key_hit && key_slot == sweep_idx);
  assign sweep_move = sweep_en && (sweep_sum < (Y_W+1)'(LOWER_BOUND));

  assign miss_inc   = {1'b0, sweep_out} + {1'b0, key_miss};
  assign misses_sum = {1'b0, misses} + {7'd0, miss_inc};
  assign misses_d   = (misses_sum >= 9'(MAX_MISS)) ? 8'(MAX_MISS) : misses_sum[7:0];
  assign count_d    = active_count + CNT_W'(spawn_fire) - CNT_W'(key_hit) - CNT_W'(sweep_out);

  always_comb begin
    state_d     = state_q;
    sweep_idx_d = sweep_idx;
    pend_d      = pend_q;
    if (gameover) begin
      state_d     = S_IDLE;
      sweep_idx_d = '0;
      pend_d      = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (frame_tick || pend_q) begin
            state_d     = S_SWEEP;
            sweep_idx_d = '0;
            pend_d      = 1'b0;
          end
        end
        S_SWEEP: begin
          pend_d = pend_q || frame_tick;
          if (sweep_idx == IDX_W'(SLOTS - 1)) begin
            state_d     = S_IDLE;
            sweep_idx_d = '0;
          end else begin
            sweep_idx_d = sweep_idx + 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      sweep_idx <= '0;
      pend_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sweep_idx <= sweep_idx_d;
      pend_q    <= pend_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_q <= '0;
      for (int i = 0; i < SLOTS; i++) begin
        chr_q[i] <= '0;
        x_q[i]   <= '0;
        y_q[i]   <= '0;
        spd_q[i] <= '0;
      end
    end else if (!gameover) begin
      if (sweep_move) y_q[sweep_idx] <= sweep_sum[Y_W-1:0];
      if (sweep_out)  act_q[sweep_idx] <= 1'b0;
      if (key_hit)    act_q[key_slot] <= 1'b0;
      if (spawn_fire) begin
        act_q[spawn_slot] <= 1'b1;
        chr_q[spawn_slot] <= spawn_char;
        x_q[spawn_slot]   <= spawn_x;
        y_q[spawn_slot]   <= '0;
        spd_q[spawn_slot] <= spawn_speed;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      score        <= '0;
      misses       <= '0;
      active_count <= '0;
      gameover     <= 1'b0;
      hit_pulse    <= 1'b0;
      miss_pulse   <= 1'b0;
    end else begin
      hit_pulse    <= key_hit;
      miss_pulse   <= sweep_out || key_miss;
      misses       <= misses_d;
      active_count <= count_d;
      gameover     <= gameover || (misses_d >= 8'(MAX_MISS));
      if (key_hit && score != 16'hFFFF) score <= score + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_active <= 1'b0;
      rd_char   <= '0;
      rd_x      <= '0;
      rd_y      <= '0;
    end else begin
      rd_active <= act_q[rd_idx];
      rd_char   <= act_q[rd_idx] ? chr_q[rd_idx] : 8'd0;
      rd_x      <= act_q[rd_idx] ? x_q[rd_idx]   : '0;
      rd_y      <= act_q[rd_idx] ? y_q[rd_idx]   : '0;
    end
  end

endmodule

// File: tb/tb_char_rain_engine.sv
// tb/tb_char_rain_engine.sv - directed self-checking bench for char_rain_engine.
module tb_char_rain_engine;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic       spawn_valid = 1'b0;
  logic       spawn_ready;
  logic [7:0] spawn_char = '0;
  logic [9:0] spawn_x = '0;
  logic [3:0] spawn_speed = '0;
  logic       key_valid = 1'b0;
  logic [7:0] key_char = '0;
  logic [2:0] rd_idx = '0;
  logic       rd_active;
  logic [7:0] rd_char;
  logic [9:0] rd_x;
  logic [9:0] rd_y;
  logic       hit_pulse, miss_pulse;
  logic [15:0] score;
  logic [7:0] misses;
  logic [3:0] active_count;
  logic       gameover;

  int n_checks = 0;
  int n_errors = 0;
  int miss_seen = 0;
  int miss_base;

  char_rain_engine dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick),
    .spawn_valid(spawn_valid), .spawn_ready(spawn_ready),
    .spawn_char(spawn_char), .spawn_x(spawn_x), .spawn_speed(spawn_speed),
    .key_valid(key_valid), .key_char(key_char), .rd_idx(rd_idx),
    .rd_active(rd_active), .rd_char(rd_char), .rd_x(rd_x), .rd_y(rd_y),
    .hit_pulse(hit_pulse), .miss_pulse(miss_pulse), .score(score),
    .misses(misses), .active_count(active_count), .gameover(gameover)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (miss_pulse) miss_seen++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic spawn(input logic [7:0] c, input logic [9:0] x, input logic [3:0] spd);
    spawn_valid = 1'b1; spawn_char = c; spawn_x = x; spawn_speed = spd;
    step();
    spawn_valid = 1'b0;
  endtask

  task automatic key(input logic [7:0] c);
    key_valid = 1'b1; key_char = c;
    step();
    key_valid = 1'b0;
  endtask

  task automatic frame();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    repeat (9) step();
  endtask

  task automatic read(input logic [2:0] idx);
    rd_idx = idx;
    step();
  endtask

  initial begin
    repeat (2) step();
    rst_n = 1'b1;
    step();

    // reset state
    check("rst_ready", spawn_ready, 1);
    check("rst_count", active_count, 0);
    check("rst_score", score, 0);
    check("rst_misses", misses, 0);
    check("rst_gameover", gameover, 0);
    check("rst_hit", hit_pulse, 0);
    check("rst_miss", miss_pulse, 0);
    check("rst_rd_active", rd_active, 0);
    check("rst_rd_y", rd_y, 0);

    // 'A' at x=100 speed 4, three frames -> y=12
    spawn(8'h41, 10'd100, 4'd4);
    repeat (3) frame();
    read(3'd0);
    check("a_active", rd_active, 1);
    check("a_char", rd_char, 8'h41);
    check("a_x", rd_x, 100);
    check("a_y", rd_y, 12);
    check("a_count", active_count, 1);
    read(3'd1);
    check("empty_rd_active", rd_active, 0);
    check("empty_rd_y", rd_y, 0);

    // fill all slots, slot 3 holds 'B'; held spawn waits for the freed slot
    do_reset();
    for (int i = 0; i < 8; i++) spawn((i == 3) ? 8'h42 : 8'(8'h30 + i), 10'(i), 4'd0);
    check("full_ready", spawn_ready, 0);
    check("full_count", active_count, 8);
    spawn_valid = 1'b1; spawn_char = 8'h51; spawn_x = 10'd7; spawn_speed = 4'd0;
    step();
    check("full_no_accept", active_count, 8);
    key_valid = 1'b1; key_char = 8'h42;
    step();
    key_valid = 1'b0;
    check("b_hit", hit_pulse, 1);
    check("b_score", score, 1);
    check("b_count", active_count, 7);
    check("b_ready", spawn_ready, 1);
    step();
    spawn_valid = 1'b0;
    check("q_count", active_count, 8);
    read(3'd3);
    check("q_active", rd_active, 1);
    check("q_char", rd_char, 8'h51);

    // deepest 'C' wins; equal-depth 'D' ties go to the lower index
    do_reset();
    spawn(8'h44, 10'd0, 4'd0);
    spawn(8'h44, 10'd0, 4'd0);
    spawn(8'h43, 10'd0, 4'd8);
    spawn(8'h78, 10'd0, 4'd0);
    spawn(8'h78, 10'd0, 4'd0);
    spawn(8'h43, 10'd0, 4'd4);
    repeat (10) frame();
    key(8'h43);
    check("c_score", score, 1);
    read(3'd2);
    check("c_slot2_freed", rd_active, 0);
    read(3'd5);
    check("c_slot5_active", rd_active, 1);
    check("c_slot5_y", rd_y, 40);
    key(8'h44);
    read(3'd0);
    check("d_slot0_freed", rd_active, 0);
    read(3'd1);
    check("d_slot1_active", rd_active, 1);

    // bottom boundary: 476+4 misses, 472+4 survives
    do_reset();
    spawn(8'h45, 10'd0, 4'd4);
    frame();
    spawn(8'h46, 10'd0, 4'd4);
    repeat (118) frame();
    read(3'd0);
    check("e_y476", rd_y, 476);
    miss_base = miss_seen;
    frame();
    check("e_misses", misses, 1);
    check("e_pulses", miss_seen - miss_base, 1);
    check("e_count", active_count, 1);
    read(3'd0);
    check("e_freed", rd_active, 0);
    read(3'd1);
    check("f_y476", rd_y, 476);
    // key lands in the same cycle slot 1 is swept
    miss_base = miss_seen;
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    step();
    key(8'h46);
    check("f_hit", hit_pulse, 1);
    check("f_no_miss", miss_pulse, 0);
    repeat (9) step();
    check("f_misses", misses, 1);
    check("f_score", score, 1);
    check("f_count", active_count, 0);
    check("f_pulses", miss_seen - miss_base, 0);

    // eight misses end the game
    do_reset();
    for (int i = 0; i < 7; i++) spawn(8'h47, 10'd0, 4'd15);
    spawn(8'h48, 10'd0, 4'd0);
    repeat (32) frame();
    check("g_misses7", misses, 7);
    check("g_not_over", gameover, 0);
    spawn(8'h47, 10'd0, 4'd15);
    repeat (32) frame();
    check("g_misses8", misses, 8);
    check("g_over", gameover, 1);
    check("g_ready", spawn_ready, 0);
    check("g_count", active_count, 1);
    key(8'h48);
    check("g_score", score, 0);
    check("g_no_hit", hit_pulse, 0);
    check("g_count_frozen", active_count, 1);
    frame();
    check("g_misses_frozen", misses, 8);
    #2 rst_n = 1'b0;
    #1;
    check("arst_gameover", gameover, 0);
    check("arst_misses", misses, 0);
    check("arst_count", active_count, 0);
    check("arst_ready", spawn_ready, 1);
    step();
    rst_n = 1'b1;

    // ticks during a sweep: one latched, one dropped -> two sweeps
    spawn(8'h4A, 10'd0, 4'd1);
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    step();
    frame_tick = 1'b1;
    step();
    step();
    frame_tick = 1'b0;
    repeat (30) step();
    read(3'd0);
    check("two_sweeps_y", rd_y, 2);
    miss_base = miss_seen;
    key(8'h5A);
    step();
`ifdef CHAR_RAIN_WRONG_KEY_PENALTY_EN
    check("z_misses", misses, 1);
    check("z_pulses", miss_seen - miss_base, 1);
`else
    check("z_misses", misses, 0);
    check("z_pulses", miss_seen - miss_base, 0);
`endif
    check("z_score", score, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
